axis_rr_arb_mux: RTL

- Packet-level round-robin arbiter and mux: shares one AXI-Stream sink (typically the write side of an async FIFO) between PORTS requesters.
- Grants one input per packet and holds the grant until the tlast beat is accepted.
- Forwards beats through a single registered output stage.
- Single clock domain; sits on the input_clk side of the FIFO.

---
 rtl/axis_rr_arb_mux_pkg.sv | 37 +++
 rtl/axis_rr_arb_mux_pick.sv | 25 ++
 rtl/axis_rr_arb_mux.sv | 109 ++++++++++
 3 files changed

// File: rtl/axis_rr_arb_mux_pkg.sv
// Shared types and helpers for the packet round-robin arbiter/mux.
// The rr_next search is written for up to MAX_PORTS requesters so other arbiters can reuse it.
package axis_rr_arb_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int MAX_PORTS = 8;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } pick_t;

  // First requester strictly after 'last' in circular order. The loop runs from the
  // farthest candidate to the nearest, so the nearest requester is the one kept.
  function automatic pick_t rr_next(input logic [MAX_PORTS-1:0] req,
                                    input logic [2:0]           last,
                                    input int                   ports);
    pick_t res;
    int    idx;
    res = '0;
    for (int k = MAX_PORTS; k >= 1; k--) begin
      if (k <= ports) begin
        idx = (int'(last) + k) % ports;
        if (req[3'(idx)]) begin
          res.hit = 1'b1;
          res.idx = 3'(idx);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_rr_arb_mux_pick.sv
// Combinational round-robin priority encoder: next requester after last_idx, with wrap.
module axis_rr_pick
  import axis_rr_arb_mux_pkg::*;
#(
  parameter int PORTS     = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [PORTS-1:0]     req,
  input  logic [IDX_WIDTH-1:0] last_idx,
  output logic [IDX_WIDTH-1:0] next_idx,
  output logic                 hit
);

  logic [MAX_PORTS-1:0] req_ext;
  pick_t                pick;

  always_comb begin
    req_ext                = '0;
    req_ext[PORTS-1:0]     = req;
    pick                   = rr_next(req_ext, 3'(last_idx), PORTS);
    hit                    = pick.hit;
    next_idx               = IDX_WIDTH'(pick.idx);
  end

endmodule

// File: rtl/axis_rr_arb_mux.sv
// Packet-level round-robin AXI-Stream arbiter/mux with a single registered output stage.
// A grant is held from the first accepted beat until the tlast beat is accepted.
module axis_rr_arb_mux
  import axis_rr_arb_mux_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                        clk,
  input  logic                        async_rst,
  input  logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [PORTS-1:0]            input_axis_tvalid,
  output logic [PORTS-1:0]            input_axis_tready,
  input  logic [PORTS-1:0]            input_axis_tlast,
  input  logic [PORTS-1:0]            input_axis_tuser,
  output logic [DATA_WIDTH-1:0]       output_axis_tdata,
  output logic                        output_axis_tvalid,
  input  logic                        output_axis_tready,
  output logic                        output_axis_tlast,
  output logic                        output_axis_tuser,
  output logic                        grant_valid,
  output logic [IDX_WIDTH-1:0]        grant_index
);

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  grant_index_q, grant_index_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  out_user_q, out_user_d;
  logic                  out_valid_q, out_valid_d;

  logic [IDX_WIDTH-1:0]  pick_idx;
  logic                  pick_hit;
  logic                  gnt_ready;
  logic                  accept;

  axis_rr_pick #(
    .PORTS     (PORTS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick (
    .req      (input_axis_tvalid),
    .last_idx (grant_index_q),
    .next_idx (pick_idx),
    .hit      (pick_hit)
  );

  // The output register can take a new beat when empty or draining this cycle.
  assign gnt_ready = (state_q == ACTIVE) && (output_axis_tready || !out_valid_q);
  assign accept    = gnt_ready && input_axis_tvalid[grant_index_q];

  always_comb begin
    input_axis_tready                = '0;
    input_axis_tready[grant_index_q] = gnt_ready;
  end

  always_comb begin
    state_d       = state_q;
    grant_index_d = grant_index_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    out_user_d    = out_user_q;
    out_valid_d   = out_valid_q && !output_axis_tready;
    case (state_q)
      IDLE: begin
        if (pick_hit) begin
          grant_index_d = pick_idx;
          state_d       = ACTIVE;
        end
      end
      ACTIVE: begin
        if (accept) begin
          out_data_d  = input_axis_tdata[grant_index_q*DATA_WIDTH +: DATA_WIDTH];
          out_last_d  = input_axis_tlast[grant_index_q];
          out_user_d  = input_axis_tuser[grant_index_q];
          out_valid_d = 1'b1;
          if (input_axis_tlast[grant_index_q]) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q       <= IDLE;
      grant_index_q <= IDX_WIDTH'(PORTS - 1);
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      out_user_q    <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_index_q <= grant_index_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      out_user_q    <= out_user_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign output_axis_tdata  = out_data_q;
  assign output_axis_tvalid = out_valid_q;
  assign output_axis_tlast  = out_last_q;
  assign output_axis_tuser  = out_user_q;
  assign grant_valid        = (state_q == ACTIVE);
  assign grant_index        = grant_index_q;

endmodule
